// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and state encoding for the TX and RX blocks
package uart_pkg;

  localparam int OVERSAMPLE  = 16;
  localparam int DBIT_DEF    = 8;
  localparam int SB_TICK_DEF = 16;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    START = ST_START,
    DATA  = ST_DATA,
    STOP  = ST_STOP
  } state_t;

endpackage

// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - UART frame serializer paced by an external 16x s_tick
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int DBIT    = DBIT_DEF,
  parameter int SB_TICK = SB_TICK_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            tx_start,
  input  logic [DBIT-1:0] din,
  output logic            tx_busy,
  output logic            tx_done_tick,
  output logic            tx
);

  localparam logic [4:0] TICK_LAST = 5'(OVERSAMPLE - 1);
  localparam logic [4:0] STOP_LAST = 5'(SB_TICK - 1);
  localparam logic [2:0] BIT_LAST  = 3'(DBIT - 1);

  state_t          state_q, state_n;
  logic [4:0]      tick_q, tick_n;
  logic [2:0]      bit_q, bit_n;
  logic [DBIT-1:0] sh_q, sh_n;
  logic            tx_q, tx_n;
  logic            busy_q, busy_n;
  logic            done_q, done_n;

  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    unique case (state_q)
      IDLE:  if (tx_start) state_n = START;
      START: if (s_tick && tick_q == TICK_LAST) state_n = DATA;
      DATA:  if (s_tick && tick_q == TICK_LAST && bit_q == BIT_LAST) state_n = STOP;
      STOP:  if (s_tick && tick_q == STOP_LAST) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    tick_n = tick_q;
    bit_n  = bit_q;
    sh_n   = sh_q;
    busy_n = busy_q;
    done_n = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (tx_start) begin
          sh_n   = din;
          tick_n = 5'd0;
          busy_n = 1'b1;
        end
      end
      START: begin
        if (s_tick) begin
          if (tick_q == TICK_LAST) begin
            tick_n = 5'd0;
            bit_n  = 3'd0;
          end else begin
            tick_n = tick_q + 5'd1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (tick_q == TICK_LAST) begin
            tick_n = 5'd0;
            sh_n   = sh_q >> 1;
            if (bit_q != BIT_LAST) bit_n = bit_q + 3'd1;
          end else begin
            tick_n = tick_q + 5'd1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (tick_q == STOP_LAST) begin
            done_n = 1'b1;
            busy_n = 1'b0;
          end else begin
            tick_n = tick_q + 5'd1;
          end
        end
      end
      default: ;
    endcase
    // Line level is derived from where the FSM lands, so tx changes on the same edge as the state.
    unique case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = sh_n[0];
      default: tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      tick_q <= 5'd0;
      bit_q  <= 3'd0;
      sh_q   <= '0;
      tx_q   <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      tick_q <= tick_n;
      bit_q  <= bit_n;
      sh_q   <= sh_n;
      tx_q   <= tx_n;
      busy_q <= busy_n;
      done_q <= done_n;
    end
  end

  assign tx           = tx_q;
  assign tx_busy      = busy_q;
  assign tx_done_tick = done_q;

endmodule
